img_rsz_blk_avg: RTL

- Resizer compute engine, directly downstream of the image capturer. Consumes its delayed pixel stream (data, X, Y, valid/ready) and its block sizes.
- Averages each BlkSzHor x BlkSzVer block of the source image into one resized pixel, using one row of per-column accumulators.
- Emits resized pixels serially on a valid/ready port. Returns a forward pulse to the capturer, which uses it for image-completion tracking.

---
 rtl/img_rsz_blk_avg_pkg.sv | 48 ++++
 rtl/img_rsz_out_reg.sv | 53 +++++
 rtl/img_rsz_blk_avg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/img_rsz_blk_avg_pkg.sv
// Shared types, widths and helpers for the block-averaging resizer.
// Optional rounding is selected in the top with the IMG_RSZ_ROUND_EN macro.
package img_rsz_blk_avg_pkg;

    localparam int unsigned RSZ_IMG_WIDTH_SIZE  = 2;
    localparam int unsigned RSZ_IMG_HEIGHT_SIZE = 2;
    localparam int unsigned PXL_PRIM_COLOR_NUM  = 3;
    localparam int unsigned PXL_PRIM_COLOR_W    = 8;

    localparam int unsigned BLK_WIDTH_MAX_SZ    = 8;
    localparam int unsigned BLK_HEIGHT_MAX_SZ   = 8;
    localparam int unsigned BLK_WIDTH_MAX_SZ_W  = $clog2(BLK_WIDTH_MAX_SZ + 1);
    localparam int unsigned BLK_HEIGHT_MAX_SZ_W = $clog2(BLK_HEIGHT_MAX_SZ + 1);

    localparam int unsigned IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE * BLK_WIDTH_MAX_SZ);
    localparam int unsigned IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE * BLK_HEIGHT_MAX_SZ);
    localparam int unsigned RSZ_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE);
    localparam int unsigned RSZ_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE);

    // Accumulator holds a full block sum of the largest block without overflow.
    localparam int unsigned RSZ_ACC_W = PXL_PRIM_COLOR_W + BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W;

    localparam int unsigned BLK_LG_H_W   = $clog2(BLK_WIDTH_MAX_SZ_W);
    localparam int unsigned BLK_LG_V_W   = $clog2(BLK_HEIGHT_MAX_SZ_W);
    localparam int unsigned BLK_LG_SUM_W = ((BLK_LG_H_W > BLK_LG_V_W) ? BLK_LG_H_W : BLK_LG_V_W) + 1;

    typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] FcRszPxlData_t;

    typedef struct packed {
        FcRszPxlData_t                 data;
        logic [RSZ_WIDTH_IDX_W-1:0]    x;
        logic [RSZ_HEIGHT_IDX_W-1:0]   y;
        logic                          last;
    } rsz_pxl_t;

    // Index of the highest set bit; a zero size maps to 0 (treated as 1).
    function automatic int unsigned log2_pow2(input logic [31:0] sz);
        int unsigned lg;
        lg = 0;
        for (int i = 0; i < 32; i++) begin
            if (sz[i]) begin
                lg = i;
            end
        end
        return lg;
    endfunction

endpackage

// File: rtl/img_rsz_out_reg.sv
// One-entry valid/ready output register; can drain and reload in the same cycle.
module img_rsz_out_reg
    import img_rsz_blk_avg_pkg::*;
(
    input  logic     Clk,
    input  logic     Reset,
    input  logic     load_i,
    input  rsz_pxl_t load_pxl_i,
    input  logic     rdy_i,
    output logic     vld_o,
    output rsz_pxl_t pxl_o,
    output logic     free_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t   state_q;
    rsz_pxl_t pxl_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_EMPTY;
            pxl_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (load_i) begin
                        state_q <= ST_FULL;
                        pxl_q   <= load_pxl_i;
                    end
                end
                ST_FULL: begin
                    if (rdy_i) begin
                        if (load_i) begin
                            pxl_q <= load_pxl_i;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign vld_o  = (state_q == ST_FULL);
    assign pxl_o  = pxl_q;
    assign free_o = (state_q == ST_EMPTY) | rdy_i;

endmodule

// File: rtl/img_rsz_blk_avg.sv
// Block-averaging resizer: per-column accumulators reduce each source block to one pixel.
// Define IMG_RSZ_ROUND_EN for round-half-up averaging instead of truncation.
module img_rsz_blk_avg
    import img_rsz_blk_avg_pkg::*;
(
    input  logic                           Clk,
    input  logic                           Reset,
    input  FcRszPxlData_t                  PxlData_d1,
    input  logic [IMG_WIDTH_IDX_W-1:0]     PxlX_d1,
    input  logic [IMG_HEIGHT_IDX_W-1:0]    PxlY_d1,
    input  logic                           PxlVld_d1,
    output logic                           PxlRdy_d1,
    input  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor,
    input  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer,
    output FcRszPxlData_t                  RszPxlData,
    output logic [RSZ_WIDTH_IDX_W-1:0]     RszPxlX,
    output logic [RSZ_HEIGHT_IDX_W-1:0]    RszPxlY,
    output logic                           RszPxlLast,
    output logic                           RszPxlVld,
    input  logic                           RszPxlRdy,
    output logic                           FwdRszEn
);

    logic                          accept;
    logic                          frame_start;
    logic                          blk_end;
    logic [BLK_LG_H_W-1:0]         lg_h_q;
    logic [BLK_LG_H_W-1:0]         lg_h;
    logic [BLK_LG_V_W-1:0]         lg_v_q;
    logic [BLK_LG_V_W-1:0]         lg_v;
    logic [BLK_LG_SUM_W-1:0]       lg_sum;
    logic [IMG_WIDTH_IDX_W-1:0]    x_mask;
    logic [IMG_HEIGHT_IDX_W-1:0]   y_mask;
    logic [RSZ_WIDTH_IDX_W-1:0]    col;
    logic [RSZ_HEIGHT_IDX_W-1:0]   row;

    logic [RSZ_IMG_WIDTH_SIZE-1:0][PXL_PRIM_COLOR_NUM-1:0][RSZ_ACC_W-1:0] acc_q;
    logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_ACC_W-1:0] sum;
    logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_ACC_W-1:0] sum_rnd;
    FcRszPxlData_t                                avg;

    rsz_pxl_t load_pxl;
    rsz_pxl_t out_pxl;

    assign accept      = PxlVld_d1 & PxlRdy_d1;
    assign frame_start = accept && (PxlX_d1 == '0) && (PxlY_d1 == '0);

    // The first pixel of an image already uses the freshly presented block size.
    assign lg_h = frame_start ? BLK_LG_H_W'(log2_pow2(32'(BlkSzHor))) : lg_h_q;
    assign lg_v = frame_start ? BLK_LG_V_W'(log2_pow2(32'(BlkSzVer))) : lg_v_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lg_h_q <= '0;
            lg_v_q <= '0;
        end else if (frame_start) begin
            lg_h_q <= lg_h;
            lg_v_q <= lg_v;
        end
    end

    // Masks come from the encoded log2 so a non-power-of-2 size still closes blocks.
    assign x_mask  = IMG_WIDTH_IDX_W'((32'd1 << lg_h) - 32'd1);
    assign y_mask  = IMG_HEIGHT_IDX_W'((32'd1 << lg_v) - 32'd1);
    assign blk_end = ((PxlX_d1 & x_mask) == x_mask) && ((PxlY_d1 & y_mask) == y_mask);
    assign col     = RSZ_WIDTH_IDX_W'(PxlX_d1 >> lg_h);
    assign row     = RSZ_HEIGHT_IDX_W'(PxlY_d1 >> lg_v);
    assign lg_sum  = BLK_LG_SUM_W'(lg_h) + BLK_LG_SUM_W'(lg_v);

`ifdef IMG_RSZ_ROUND_EN
    logic [RSZ_ACC_W-1:0] rnd;
    assign rnd = (lg_sum == '0) ? '0 : (RSZ_ACC_W'(1) << (lg_sum - BLK_LG_SUM_W'(1)));
`endif

    always_comb begin
        sum     = '0;
        sum_rnd = '0;
        avg     = '0;
        for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
            sum[c] = acc_q[col][c] + RSZ_ACC_W'(PxlData_d1[c]);
`ifdef IMG_RSZ_ROUND_EN
            sum_rnd[c] = sum[c] + rnd;
`else
            sum_rnd[c] = sum[c];
`endif
            avg[c] = PXL_PRIM_COLOR_W'(sum_rnd[c] >> lg_sum);
        end
    end

    // Column accumulators restart from zero once their block has been emitted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_q <= '0;
        end else if (accept) begin
            for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
                acc_q[col][c] <= blk_end ? '0 : sum[c];
            end
        end
    end

    always_comb begin
        load_pxl      = '0;
        load_pxl.data = avg;
        load_pxl.x    = col;
        load_pxl.y    = row;
        load_pxl.last = (col == RSZ_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1)) &&
                        (row == RSZ_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1));
    end

    img_rsz_out_reg u_out_reg (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (accept & blk_end),
        .load_pxl_i (load_pxl),
        .rdy_i      (RszPxlRdy),
        .vld_o      (RszPxlVld),
        .pxl_o      (out_pxl),
        .free_o     (PxlRdy_d1)
    );

    assign RszPxlData = out_pxl.data;
    assign RszPxlX    = out_pxl.x;
    assign RszPxlY    = out_pxl.y;
    assign RszPxlLast = out_pxl.last;
    assign FwdRszEn   = RszPxlVld & RszPxlRdy;

endmodule
